overdrive_agc_controller: RTL and testbench

Closed-loop gain controller that sits on the ADC sample stream beside the overdrive warning block and drives the RF front-end step attenuator code.
- Tracks the peak magnitude of valid samples over fixed windows.
- Fast attack: raises attenuation immediately when a sample crosses the overload threshold.
- Slow decay: lowers attenuation one step per quiet window.
- Enforces a settling holdoff after every attenuator change.

---
 rtl/overdrive_agc_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_overdrive_agc_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/overdrive_agc_controller.sv
// -----------------------------------------------------------------------------
// overdrive_agc_controller
//
// Closed-loop gain controller on the ADC sample stream. It measures the peak
// magnitude of valid samples over fixed-length windows and drives the RF
// front-end step attenuator code:
//   - fast attack: any sample at or above HIGH_THRESH raises the code by
//     ATTACK_STEP (clamped to MAX_ATTEN),
//   - slow decay: a window whose peak stays below LOW_THRESH lowers the code
//     by one,
//   - every attenuator update is followed by a settling holdoff during which
//     samples are not measured.
//
// Ports
//   i_clk           system clock, rising edge
//   i_resetn        synchronous active-low reset
//   iS_data         signed two's-complement ADC sample
//   i_valid         qualifier for iS_data
//   i_enable        loop enable; 0 returns the FSM to IDLE and freezes o_atten
//   o_atten         registered attenuator code
//   o_atten_update  one-cycle pulse in the cycle o_atten takes a new value
//   o_overdrive     sticky overload flag, cleared by a window without overload
//   o_clip          one-cycle pulse one cycle after a full-scale valid sample
//   o_state         FSM state: 0 IDLE, 1 MEASURE, 2 ATTACK, 3 HOLDOFF
// -----------------------------------------------------------------------------
module overdrive_agc_controller #(
   parameter int DATA_WIDTH     = 16,
   parameter int ATTEN_BITS     = 6,
   parameter int MAX_ATTEN      = 63,
   parameter int ATTACK_STEP    = 4,
   parameter int HIGH_THRESH    = 30000,
   parameter int LOW_THRESH     = 8192,
   parameter int WINDOW_LEN     = 1024,
   parameter int HOLDOFF_CYCLES = 256
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   input  logic [DATA_WIDTH-1:0] iS_data,
   input  logic                  i_valid,
   input  logic                  i_enable,
   output logic [ATTEN_BITS-1:0] o_atten,
   output logic                  o_atten_update,
   output logic                  o_overdrive,
   output logic                  o_clip,
   output logic [1:0]            o_state
);

   localparam int MAG_W  = DATA_WIDTH - 1;
   localparam int CNT_W  = $clog2(WINDOW_LEN);
   localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   localparam logic [MAG_W-1:0]      MAG_ZERO   = {MAG_W{1'b0}};
   localparam logic [MAG_W-1:0]      MAG_ONE    = MAG_W'(1);
   localparam logic [MAG_W-1:0]      MAG_MAX    = {MAG_W{1'b1}};
   localparam logic [MAG_W-1:0]      HIGH_MAG   = MAG_W'(HIGH_THRESH);
   localparam logic [MAG_W-1:0]      LOW_MAG    = MAG_W'(LOW_THRESH);
   localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(WINDOW_LEN - 1);
   localparam logic [HOLD_W-1:0]     HOLD_ZERO  = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0]     HOLD_ONE   = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [ATTEN_BITS-1:0] ATTEN_ZERO = {ATTEN_BITS{1'b0}};
   localparam logic [ATTEN_BITS-1:0] ATTEN_ONE  = ATTEN_BITS'(1);
   localparam logic [ATTEN_BITS-1:0] ATTEN_MAX  = ATTEN_BITS'(MAX_ATTEN);
   localparam logic [ATTEN_BITS:0]   STEP_EXT   = (ATTEN_BITS + 1)'(ATTACK_STEP);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_ATTACK  = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   state_t                state_r,     state_s;
   logic [ATTEN_BITS-1:0] atten_r,     atten_s;
   logic                  update_r,    update_s;
   logic                  overdrive_r, overdrive_s;
   logic                  clip_r;
   logic [MAG_W-1:0]      peak_r,      peak_s;
   logic [CNT_W-1:0]      cnt_r,       cnt_s;
   logic [HOLD_W-1:0]     hold_r,      hold_s;

   logic [MAG_W-1:0]      mag_s;
   logic                  full_s;
   logic [MAG_W-1:0]      peak_new_s;
   logic [ATTEN_BITS:0]   attack_sum_s;
   logic [ATTEN_BITS-1:0] attack_code_s;

   // Saturated magnitude and full-scale detect of the incoming sample.
   always_comb begin
      mag_s  = MAG_ZERO;
      full_s = 1'b0;
      if (iS_data[DATA_WIDTH-1] == 1'b0) begin
         mag_s  = iS_data[MAG_W-1:0];
         full_s = (iS_data[MAG_W-1:0] == MAG_MAX);
      end else if (iS_data[MAG_W-1:0] == MAG_ZERO) begin
         // Most negative code has no positive counterpart: saturate.
         mag_s  = MAG_MAX;
         full_s = 1'b1;
      end else begin
         // For negative x, |x| = ~x + 1 and always fits in MAG_W bits here.
         mag_s  = ~iS_data[MAG_W-1:0] + MAG_ONE;
         full_s = 1'b0;
      end
   end

   // Running peak including the current sample and the clamped attack code.
   always_comb begin
      peak_new_s   = (mag_s > peak_r) ? mag_s : peak_r;
      attack_sum_s = {1'b0, atten_r} + STEP_EXT;
      if (attack_sum_s > {1'b0, ATTEN_MAX}) begin
         attack_code_s = ATTEN_MAX;
      end else begin
         attack_code_s = attack_sum_s[ATTEN_BITS-1:0];
      end
   end

   // Next-state and next-output logic of the AGC loop.
   always_comb begin
      state_s     = state_r;
      atten_s     = atten_r;
      update_s    = 1'b0;
      overdrive_s = overdrive_r;
      peak_s      = peak_r;
      cnt_s       = cnt_r;
      hold_s      = hold_r;
      if (!i_enable) begin
         // Disable wins over every transition; code and flag are frozen.
         state_s = ST_IDLE;
         peak_s  = MAG_ZERO;
         cnt_s   = CNT_ZERO;
         hold_s  = HOLD_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               peak_s  = MAG_ZERO;
               cnt_s   = CNT_ZERO;
               hold_s  = HOLD_ZERO;
               state_s = ST_MEASURE;
            end
            ST_MEASURE: begin
               if (i_valid) begin
                  if (mag_s >= HIGH_MAG) begin
                     // Overload beats window completion.
                     state_s     = ST_ATTACK;
                     overdrive_s = 1'b1;
                     hold_s      = HOLD_ZERO;
                  end else if (cnt_r == CNT_LAST) begin
                     peak_s = MAG_ZERO;
                     cnt_s  = CNT_ZERO;
                     if (peak_new_s < HIGH_MAG) begin
                        overdrive_s = 1'b0;
                     end else begin
                        overdrive_s = overdrive_r;
                     end
                     if ((peak_new_s < LOW_MAG) && (atten_r != ATTEN_ZERO)) begin
                        atten_s  = atten_r - ATTEN_ONE;
                        update_s = 1'b1;
                        state_s  = ST_HOLDOFF;
                        hold_s   = HOLD_ZERO;
                     end else begin
                        state_s = ST_MEASURE;
                     end
                  end else begin
                     peak_s = peak_new_s;
                     cnt_s  = cnt_r + CNT_ONE;
                  end
               end else begin
                  state_s = ST_MEASURE;
               end
            end
            ST_ATTACK: begin
               atten_s  = attack_code_s;
               update_s = (attack_code_s != atten_r);
               state_s  = ST_HOLDOFF;
               hold_s   = HOLD_ZERO;
            end
            ST_HOLDOFF: begin
               if (hold_r == HOLD_LAST) begin
                  state_s = ST_MEASURE;
                  hold_s  = HOLD_ZERO;
                  peak_s  = MAG_ZERO;
                  cnt_s   = CNT_ZERO;
               end else begin
                  hold_s = hold_r + HOLD_ONE;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         state_r     <= ST_IDLE;
         atten_r     <= ATTEN_MAX;
         update_r    <= 1'b0;
         overdrive_r <= 1'b0;
         clip_r      <= 1'b0;
         peak_r      <= MAG_ZERO;
         cnt_r       <= CNT_ZERO;
         hold_r      <= HOLD_ZERO;
      end else begin
         state_r     <= state_s;
         atten_r     <= atten_s;
         update_r    <= update_s;
         overdrive_r <= overdrive_s;
         // Clip reporting runs in every state, including holdoff.
         clip_r      <= i_valid & full_s;
         peak_r      <= peak_s;
         cnt_r       <= cnt_s;
         hold_r      <= hold_s;
      end
   end

   assign o_atten        = atten_r;
   assign o_atten_update = update_r;
   assign o_overdrive    = overdrive_r;
   assign o_clip         = clip_r;
   assign o_state        = state_r;

endmodule

// File: tb/tb_overdrive_agc_controller.sv
// -----------------------------------------------------------------------------
// tb_overdrive_agc_controller
//
// Directed scenarios followed by a randomized run. Every cycle the outputs are
// compared against a behavioural model that tracks the window as a sample
// count and a running peak, and the holdoff as a countdown of remaining clocks.
// -----------------------------------------------------------------------------
module tb_overdrive_agc_controller;

   localparam int WL  = 16;
   localparam int HC  = 8;
   localparam int HI  = 30000;
   localparam int LO  = 8192;
   localparam int AMX = 63;
   localparam int STP = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] data;
   logic        valid;
   logic        enable;
   logic [5:0]  o_atten;
   logic        o_atten_update;
   logic        o_overdrive;
   logic        o_clip;
   logic [1:0]  o_state;

   int passed = 0;
   int total  = 0;

   // reference model state
   int m_state = 0;
   int m_atten = 0;
   int m_peak  = 0;
   int m_cnt   = 0;
   int m_hold  = 0;
   bit m_upd   = 1'b0;
   bit m_od    = 1'b0;
   bit m_clip  = 1'b0;

   overdrive_agc_controller #(
      .DATA_WIDTH(16), .ATTEN_BITS(6), .MAX_ATTEN(AMX), .ATTACK_STEP(STP),
      .HIGH_THRESH(HI), .LOW_THRESH(LO), .WINDOW_LEN(WL), .HOLDOFF_CYCLES(HC)
   ) dut (
      .i_clk(clk), .i_resetn(resetn), .iS_data(data), .i_valid(valid),
      .i_enable(enable), .o_atten(o_atten), .o_atten_update(o_atten_update),
      .o_overdrive(o_overdrive), .o_clip(o_clip), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Apply the rules of one clock edge to the model.
   task automatic model_edge(input int d, input bit v, input bit en, input bit rn);
      int mag;
      mag = (d < 0) ? -d : d;
      if (mag > 32767) mag = 32767;
      m_upd  = 1'b0;
      m_clip = v && (d == 32767 || d == -32768);
      if (!rn) begin
         m_state = 0; m_atten = AMX; m_od = 1'b0; m_clip = 1'b0;
         m_peak = 0; m_cnt = 0; m_hold = 0;
      end else if (!en) begin
         m_state = 0; m_peak = 0; m_cnt = 0;
      end else begin
         case (m_state)
            0: begin m_state = 1; m_peak = 0; m_cnt = 0; end
            1: if (v) begin
               if (mag >= HI) begin
                  m_state = 2; m_od = 1'b1;
               end else begin
                  if (mag > m_peak) m_peak = mag;
                  m_cnt++;
                  if (m_cnt == WL) begin
                     if (m_peak < HI) m_od = 1'b0;
                     if (m_peak < LO && m_atten > 0) begin
                        m_atten--; m_upd = 1'b1; m_state = 3; m_hold = HC;
                     end
                     m_peak = 0; m_cnt = 0;
                  end
               end
            end
            2: begin
               int nxt;
               nxt = (m_atten + STP > AMX) ? AMX : m_atten + STP;
               m_upd = (nxt != m_atten);
               m_atten = nxt; m_state = 3; m_hold = HC;
            end
            3: begin
               m_hold--;
               if (m_hold == 0) begin m_state = 1; m_peak = 0; m_cnt = 0; end
            end
            default: m_state = 0;
         endcase
      end
   endtask

   // One clock: drive, advance model at the edge, compare 1 time unit later.
   task automatic cyc(input int d, input bit v, input bit en = 1'b1, input bit rn = 1'b1);
      data = 16'(d); valid = v; enable = en; resetn = rn;
      @(posedge clk);
      model_edge(d, v, en, rn);
      #1;
      chk("atten",     o_atten,        m_atten);
      chk("update",    o_atten_update, m_upd);
      chk("overdrive", o_overdrive,    m_od);
      chk("clip",      o_clip,         m_clip);
      chk("state",     o_state,        m_state);
   endtask

   task automatic feed(input int n, input int d);
      repeat (n) cyc(d, 1'b1);
   endtask

   // Overload sample, then the attack cycle and the full holdoff.
   task automatic overload(input int d);
      cyc(d, 1'b1);
      repeat (HC + 1) cyc(0, 1'b0);
   endtask

   initial begin
      int pulses;
      int d;
      int sel;
      bit rn, en, v;

      // 1: reset, release with loop disabled
      repeat (3) cyc(0, 1'b0, 1'b0, 1'b0);
      cyc(0, 1'b0, 1'b0, 1'b1);
      chk("t1_atten", o_atten, 63);
      chk("t1_state", o_state, 0);
      chk("t1_flags", {o_atten_update, o_overdrive, o_clip}, 0);

      // 2: quiet input decays the code all the way to zero
      cyc(1000, 1'b1, 1'b1);
      chk("t2_measure", o_state, 1);
      feed(15, 1000);
      chk("t2_before_step", o_atten, 63);
      cyc(1000, 1'b1);
      chk("t2_first_step", o_atten, 62);
      chk("t2_first_pulse", o_atten_update, 1);
      pulses = 1;
      for (int i = 0; i < 62 * 24 + 60; i++) begin
         cyc(1000, 1'b1);
         if (o_atten_update) pulses++;
      end
      chk("t2_pulse_count", pulses, 63);
      chk("t2_floor", o_atten, 0);

      // 3: reach code 10, then one overload and a recovering window
      repeat (3) overload(32767);
      feed(48, 1000);
      chk("t3_pre_atten", o_atten, 10);
      cyc(32767, 1'b1);
      chk("t3_attack_state", o_state, 2);
      chk("t3_overdrive", o_overdrive, 1);
      chk("t3_atten_held", o_atten, 10);
      cyc(0, 1'b0);
      chk("t3_atten_up", o_atten, 14);
      chk("t3_pulse", o_atten_update, 1);
      chk("t3_holdoff", o_state, 3);
      for (int i = 0; i < HC; i++) begin
         cyc(0, 1'b0);
         chk("t3_holdoff_len", o_state, (i < HC - 1) ? 3 : 1);
      end
      feed(15, 1000);
      chk("t3_od_sticky", o_overdrive, 1);
      cyc(1000, 1'b1);
      chk("t3_od_clear", o_overdrive, 0);
      chk("t3_decay", o_atten, 13);
      repeat (HC) cyc(0, 1'b0);

      // 4: most negative sample clips and attacks; clamp at the maximum
      repeat (12) overload(32767);
      chk("t4_pre_atten", o_atten, 61);
      cyc(-32768, 1'b1);
      chk("t4_clip", o_clip, 1);
      chk("t4_attack", o_state, 2);
      cyc(0, 1'b0);
      chk("t4_clip_pulse", o_clip, 0);
      chk("t4_clamp", o_atten, 63);
      chk("t4_pulse", o_atten_update, 1);
      repeat (HC) cyc(0, 1'b0);
      cyc(32767, 1'b1);
      cyc(0, 1'b0);
      chk("t4_at_max", o_atten, 63);
      chk("t4_no_pulse", o_atten_update, 0);
      chk("t4_od_kept", o_overdrive, 1);
      repeat (HC) cyc(0, 1'b0);

      // 5: peak exactly at LOW_THRESH, then windows with i_valid gaps
      feed(15, 100);
      cyc(-8192, 1'b1);
      chk("t5_low_edge", o_atten, 63);
      chk("t5_low_nopulse", o_atten_update, 0);
      for (int i = 0; i < 32; i++) cyc(9000, 1'(i % 2));
      chk("t5_gap_loud", o_atten, 63);
      for (int i = 0; i < 31; i++) cyc(100, 1'(i % 2));
      chk("t5_gap_not_yet", o_atten, 63);
      cyc(100, 1'b1);
      chk("t5_gap_step", o_atten, 62);
      chk("t5_gap_pulse", o_atten_update, 1);

      // 6: disable mid-holdoff, reset mid-measure
      repeat (3) cyc(0, 1'b0);
      cyc(0, 1'b0, 1'b0);
      chk("t6_idle", o_state, 0);
      chk("t6_atten_held", o_atten, 62);
      cyc(0, 1'b0, 1'b1);
      feed(5, 20000);
      cyc(0, 1'b1, 1'b1, 1'b0);
      chk("t6_reset_atten", o_atten, 63);
      chk("t6_reset_state", o_state, 0);
      chk("t6_reset_flags", {o_atten_update, o_overdrive, o_clip}, 0);

      // randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         rn  = ($urandom_range(499, 0) != 0);
         en  = ($urandom_range(99, 0) != 0);
         v   = ($urandom_range(3, 0) != 0);
         sel = $urandom_range(199, 0);
         if (sel == 0)      d = 32767;
         else if (sel == 1) d = -32768;
         else if (sel == 2) d = $urandom_range(32766, 30000);
         else if (sel <= 6) d = $urandom_range(29999, 8000);
         else               d = $urandom_range(7000, 0);
         if (sel >= 2 && $urandom_range(1, 0) == 1) d = -d;
         cyc(d, v, en, rn);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
